// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver.
package ps2_pkg;

  // Deframer states.
  typedef enum logic [1:0] {
    StIdle,
    StBits,
    StCheck
  } rx_state_e;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_REL_PREFIX = 8'hF0;

  // One buffered result: prefix flags plus the scan code.
  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_entry_t;

  localparam int unsigned EntryW = $bits(ps2_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign empty    = (level_q == '0);
  assign full     = (level_q == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem_q[rd_ptr_q];
  assign level    = level_q;

  // Storage, pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: sync, glitch filter, deframer, prefix decoder, FIFO.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT    = 20000,
  parameter int unsigned DECODE     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic                   out_ext,
  output logic                   out_rel,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   parity_err,
  output logic                   frame_err,
  input  logic                   clr_err
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  logic [1:0]       clk_sync_q, data_sync_q;
  logic             filt_q, filt_flip, strobe, sdata;
  logic [FiltW-1:0] filt_cnt_q;

  rx_state_e        state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [8:0]       shift_q, shift_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic             byte_ok, parity_ev, frame_ev;

  logic             ext_q, ext_d, rel_q, rel_d;
  logic             push;
  ps2_entry_t       push_entry, head;
  logic [EntryW-1:0] head_raw;
  logic             pop, fifo_full, fifo_empty, overflow_ev;
  logic             overflow_q, parity_err_q, frame_err_q;

  // Two-flop synchronisers; index 1 is the settled sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  assign sdata     = data_sync_q[1];
  // Flip on the FILTER_LEN-th consecutive differing sample; strobe on the falling flip.
  assign filt_flip = (clk_sync_q[1] != filt_q) && (filt_cnt_q == FiltLast);
  assign strobe    = filt_flip & filt_q;

  // Clock glitch filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else if (clk_sync_q[1] == filt_q) begin
      filt_cnt_q <= '0;
    end else if (filt_flip) begin
      filt_q     <= ~filt_q;
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + 1'b1;
    end
  end

  // Deframer state, shift register and inactivity counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
    end
  end

  // Deframer next state: 8 data bits LSB first plus parity, then stop check.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tmo_d     = '0;
    byte_ok   = 1'b0;
    parity_ev = 1'b0;
    frame_ev  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (strobe && !sdata) begin
          state_d   = StBits;
          bit_cnt_d = '0;
        end
      end
      StBits: begin
        if (strobe) begin
          shift_d   = {sdata, shift_q[8:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd8) state_d = StCheck;
        end
      end
      StCheck: begin
        if (strobe) begin
          state_d = StIdle;
          if (!sdata) frame_ev = 1'b1;
          else if (!(^shift_q)) parity_ev = 1'b1;
          else byte_ok = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Mid-frame inactivity abort; a strobe always restarts the count.
    if (state_q != StIdle && !strobe) begin
      if (tmo_q == TmoLast) begin
        state_d  = StIdle;
        frame_ev = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // Prefix decoder: fold E0/F0 into flags on the next non-prefix byte.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    ext_d      = ext_q;
    rel_d      = rel_q;
    if (byte_ok) begin
      if (DECODE != 0) begin
        if (shift_q[7:0] == PS2_EXT_PREFIX) begin
          ext_d = 1'b1;
        end else if (shift_q[7:0] == PS2_REL_PREFIX) begin
          rel_d = 1'b1;
        end else begin
          push       = 1'b1;
          push_entry = '{ext: ext_q, rel: rel_q, code: shift_q[7:0]};
          ext_d      = 1'b0;
          rel_d      = 1'b0;
        end
      end else begin
        push       = 1'b1;
        push_entry = '{ext: 1'b0, rel: 1'b0, code: shift_q[7:0]};
      end
    end
  end

  assign pop         = out_valid & out_ready;
  assign overflow_ev = push & fifo_full & ~pop;

  // Pending prefix flags and sticky errors; a new event beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q        <= 1'b0;
      rel_q        <= 1'b0;
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      ext_q        <= ext_d;
      rel_q        <= rel_d;
      overflow_q   <= overflow_ev | (overflow_q & ~clr_err);
      parity_err_q <= parity_ev | (parity_err_q & ~clr_err);
      frame_err_q  <= frame_ev | (frame_err_q & ~clr_err);
    end
  end

  sync_fifo #(
    .WIDTH(EntryW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .pop_data (head_raw),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  assign head       = ps2_entry_t'(head_raw);
  assign out_valid  = ~fifo_empty;
  assign out_data   = head.code;
  assign out_ext    = head.ext;
  assign out_rel    = head.rel;
  assign overflow   = overflow_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: doc/ps2_rx.md
# ps2_rx

PS/2 device-to-host receiver, parametrised successor to the existing fixed 8-entry keyboard receiver. Filters and synchronises `ps2_clk`/`ps2_data`, deframes 11-bit frames with start/parity/stop checking and an inactivity timeout, optionally folds `E0`/`F0` prefixes into flags, and buffers results in a parametrised FIFO. Results leave on a valid/ready stream; sticky error flags report faults. Sits in the peripheral tree between the PS/2 pins and the keyboard MMIO register block.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `FILTER_LEN`, 4: consecutive equal samples before the filtered `ps2_clk` changes; ≥1.
- `TIMEOUT`, 20000: idle `clk` cycles mid-frame before abort; ≥16.
- `DECODE`, 1: 1 folds `E0`/`F0` prefixes into flags; 0 passes raw bytes.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `ps2_clk` in 1: raw PS/2 clock pin; asynchronous.
- `ps2_data` in 1: raw PS/2 data pin; asynchronous.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer accepts head.
- `out_data` out 8: scan code at head.
- `out_ext` out 1: head preceded by `E0` (0 when `DECODE=0`).
- `out_rel` out 1: head preceded by `F0` (0 when `DECODE=0`).
- `level` out $clog2(DEPTH)+1: FIFO occupancy.
- `overflow` out 1: sticky; a completed entry was dropped because the FIFO was full.
- `parity_err` out 1: sticky; a frame failed odd parity.
- `frame_err` out 1: sticky; bad stop bit or timeout.
- `clr_err` in 1: clears all three sticky flags.

## Operation
- Input path: both pins pass through 2-FF synchronisers. Filtered clock resets to 1 and changes only after `FILTER_LEN` consecutive synchronised samples differ from it. Sample strobe is a 1-cycle pulse on the filtered clock's 1→0 transition. Data is sampled from the synchronised `ps2_data` on the strobe cycle.
- Deframer FSM, states `IDLE`, `BITS`, `CHECK`:
  - `IDLE`: strobe with data 0 → `BITS`, bit count 0. Strobe with data 1 → stays `IDLE`; glitch start, no error.
  - `BITS`: shifts 8 data bits, LSB first, then the parity bit. After the 9th → `CHECK`.
  - `CHECK`: next strobe samples stop → `IDLE`. Stop 0 sets `frame_err`, drops the frame. Odd parity over data+parity failing sets `parity_err`, drops the frame. Otherwise emits the byte. Stop takes priority if both fail.
  - Timeout: in `BITS`/`CHECK`, a counter reset by each strobe that reaches `TIMEOUT` forces `IDLE`, sets `frame_err`, discards the partial frame.
- Decoder, `DECODE=1`: `E0` sets `ext_pend`; `F0` sets `rel_pend`; neither is pushed. Any other byte is pushed with `{ext_pend, rel_pend, byte}`, then both pend bits clear. Bad frames and timeouts leave pend bits unchanged. `DECODE=0`: every byte pushed with flags 0.
- FIFO: entry is 10 bits. Pop when `out_valid & out_ready`. Push accepted if not full, or if full with a pop in the same cycle. Otherwise the entry is dropped, `overflow` set, contents unchanged. Pointers wrap modulo `DEPTH`.
- Sticky flags: set by events, cleared by `clr_err`. An error event in the same cycle as `clr_err` wins; the flag reads 1 next cycle.
- Reset values: `out_valid`=0, `level`=0, all sticky flags 0, `out_ext`/`out_rel`=0, FSM `IDLE`, pend bits 0, filter/synchronisers 1, timeout counter 0. `out_data` is 0 after reset until the first push. Reset mid-frame discards the partial frame and all FIFO contents.

## Timing
- Pin 1→0 to strobe: 2 (sync) + `FILTER_LEN` cycles, given a stable pin.
- Stop-bit strobe in cycle N → push at end of N → `out_valid`=1 and `level` incremented in N+1.
- `out_data`/`out_ext`/`out_rel` are combinational from the head entry and valid whenever `out_valid`=1. They are stable while `out_valid & ~out_ready`.
- Pop at end of handshake cycle; next head visible the following cycle. Throughput 1 pop/cycle.
- Simultaneous push and pop: `level` unchanged; both take effect.

## Structure
- `ps2_pkg`: FSM state enum, `PS2_EXT_PREFIX=8'hE0`, `PS2_REL_PREFIX=8'hF0`, packed entry struct `{ext, rel, code[7:0]}`.
- Sub-module `sync_fifo` (params `WIDTH`, `DEPTH`; push/pop/full/empty/level). The receiver instantiates it with `WIDTH=10`.
- Synchroniser, filter, deframer, timeout and decoder live in `ps2_rx`.

## Test plan
- Send `1C`, then `F0 1C` with `DECODE=1` → two entries `{0,0,1C}`, `{0,1,1C}`; `level`=2; no flags set.
- Send `E0 F0 75` → single entry `{1,1,75}`. Repeat with `DECODE=0` → three raw entries `E0`, `F0`, `75`.
- Frame with wrong parity, then frame with stop=0 → no pushes; `parity_err`=1, `frame_err`=1. Assert `clr_err` → both 0 next cycle.
- Stop `ps2_clk` after 5 bits for `TIMEOUT` cycles → `frame_err`=1, FSM `IDLE`. The following valid `29` is received correctly.
- Hold `out_ready`=0 and send `DEPTH+1` bytes → `level`=`DEPTH`, `overflow`=1, first `DEPTH` bytes intact in order. Push coinciding with a pop while full → accepted, no overflow.
- Assert `rst` mid-frame with 3 entries queued → `out_valid`=0, `level`=0 next cycle. A subsequent clean frame `5A` is received.
